axis_window_trig: RTL



---
 rtl/axis_window_trig_if.sv | 18 +
 rtl/axis_window_trig.sv | 129 ++++++++++++
 2 files changed

// File: rtl/axis_window_trig_if.sv
// AXI4-Stream data/valid bundle used on both sides of the window gate.
// No tready: the downstream capture path never back-pressures.
interface axis_window_trig_if #(
  parameter int DW = 128
);
  logic [DW-1:0] tdata;
  logic          tvalid;

  modport master (
    output tdata,
    output tvalid
  );

  modport slave (
    input tdata,
    input tvalid
  );
endinterface

// File: rtl/axis_window_trig.sv
// Triggered AXI4-Stream window gate: delay, window, hold-off and retrigger.
// Data is registered every cycle; tvalid marks the window samples only.
module axis_window_trig #(
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_delay,
  input  logic [CNTR_WIDTH-1:0] cfg_length,
  input  logic [CNTR_WIDTH-1:0] cfg_holdoff,
  input  logic                  cfg_retrig,
  output logic                  sts_busy,
  output logic [31:0]           sts_count,
  axis_window_trig_if.slave     s_axis,
  axis_window_trig_if.master    m_axis
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    OPEN,
    HOLD
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] C0 = '0;
  localparam logic [CNTR_WIDTH-1:0] C1 = CNTR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0] C2 = CNTR_WIDTH'(2);

  state_t                st;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [CNTR_WIDTH-1:0] len_l;
  logic [CNTR_WIDTH-1:0] hold_l;
  logic                  rtr_l;
  logic [31:0]           cnt_q;
  logic                  rtrig;

  assign sts_count = cnt_q;
  assign rtrig     = rtr_l & s_axis.tvalid;

  function automatic state_t after_win(
    input logic [CNTR_WIDTH-1:0] h
  );
    return (h == C0) ? IDLE : HOLD;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis.tdata <= '0;
    end else begin
      m_axis.tdata <= s_axis.tdata;
    end
  end

  // cnt always holds "cycles left in this state minus one"
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st            <= IDLE;
      cnt           <= '0;
      len_l         <= '0;
      hold_l        <= '0;
      rtr_l         <= 1'b0;
      cnt_q         <= '0;
      sts_busy      <= 1'b0;
      m_axis.tvalid <= 1'b0;
    end else begin
      m_axis.tvalid <= 1'b0;
      unique case (st)
        IDLE: begin
          if (s_axis.tvalid) begin
            len_l  <= cfg_length;
            hold_l <= cfg_holdoff;
            rtr_l  <= cfg_retrig;
            cnt_q  <= cnt_q + 32'd1;
            if (cfg_delay == C1) begin
              st       <= OPEN;
              cnt      <= cfg_length;
              sts_busy <= 1'b1;
            end else if (cfg_delay != C0) begin
              st       <= DELAY;
              cnt      <= cfg_delay - C2;
              sts_busy <= 1'b1;
            end else begin
              m_axis.tvalid <= 1'b1;
              if (cfg_length != C0) begin
                st       <= OPEN;
                cnt      <= cfg_length - C1;
                sts_busy <= 1'b1;
              end else begin
                st       <= after_win(cfg_holdoff);
                cnt      <= cfg_holdoff - C1;
                sts_busy <= (cfg_holdoff != C0);
              end
            end
          end
        end
        DELAY: begin
          if (cnt == C0) begin
            st  <= OPEN;
            cnt <= len_l;
          end else begin
            cnt <= cnt - C1;
          end
        end
        OPEN: begin
          m_axis.tvalid <= 1'b1;
          if (rtrig && len_l != C0) begin
            cnt <= len_l - C1;
          end else if (!rtrig && cnt != C0) begin
            cnt <= cnt - C1;
          end else begin
            st       <= after_win(hold_l);
            cnt      <= hold_l - C1;
            sts_busy <= (hold_l != C0);
          end
        end
        HOLD: begin
          if (cnt == C0) begin
            st       <= IDLE;
            sts_busy <= 1'b0;
          end else begin
            cnt <= cnt - C1;
          end
        end
      endcase
    end
  end

endmodule
